multicycle_control_unit: RTL



---
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit handshake bundle: instruction/data memory handshakes, divider
// handshake, datapath strobes, registered controls and trap/debug status.
interface multicycle_control_unit_if;
    logic [31:0] inst;
    logic        imem_ready;
    logic        dmem_ready;
    logic        alu_done;
    logic        alu_zero;

    logic        imem_req;
    logic        dmem_req;
    logic        alu_start;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  pc_src;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_control;
    logic [2:0]  imm_control;
    logic        alu_src;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    // Control unit side
    modport master (
        input  inst, imem_ready, dmem_ready, alu_done, alu_zero,
        output imem_req, dmem_req, alu_start, ir_write, pc_write, reg_write,
               mem_write, pc_src, wb_sel, alu_control, imm_control, alu_src,
               trap, trap_cause, state
    );

    // Datapath / memory side
    modport slave (
        output inst, imem_ready, dmem_ready, alu_done, alu_zero,
        input  imem_req, dmem_req, alu_start, ir_write, pc_write, reg_write,
               mem_write, pc_src, wb_sel, alu_control, imm_control, alu_src,
               trap, trap_cause, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: latches each instruction and walks it through
// FETCH/DECODE/EXEC/ALU_WAIT/MEM/WB, raising datapath strobes per state.
// Illegal encodings and stalled handshakes (watchdog) end in a sticky TRAP.
module multicycle_control_unit #(
    parameter int ENABLE_M   = 1,
    parameter int WAIT_LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_control_unit_if.master bus
);
    localparam logic [2:0] FETCH    = 3'd0;
    localparam logic [2:0] DECODE   = 3'd1;
    localparam logic [2:0] EXEC     = 3'd2;
    localparam logic [2:0] ALU_WAIT = 3'd3;
    localparam logic [2:0] MEM      = 3'd4;
    localparam logic [2:0] WB       = 3'd5;
    localparam logic [2:0] TRAP     = 3'd6;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_REM = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [2:0] IMM_R = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The count trips one short of WAIT_LIMIT, so this width always suffices.
    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    typedef struct packed {
        logic       legal;
        logic [3:0] alu;
        logic       src;
        logic [2:0] imm;
        logic [1:0] wb;
    } dec_t;

    // Full decode of one instruction word into the controls DECODE registers.
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t       d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ir[6:0];
        f3 = ir[14:12];
        f7 = ir[31:25];
        d  = '0;
        case (op)
            OP_R: begin
                d.legal = 1'b1;
                d.imm   = IMM_R;
                d.wb    = WB_ALU;
                case ({f7, f3})
                    {F7_BASE, 3'b000}: d.alu = ALU_ADD;
                    {F7_BASE, 3'b111}: d.alu = ALU_AND;
                    {F7_ALT,  3'b000}: d.alu = ALU_SUB;
                    {F7_BASE, 3'b010}: d.alu = ALU_SLT;
                    {F7_BASE, 3'b001}: d.alu = ALU_SLL;
                    {F7_BASE, 3'b101}: d.alu = ALU_SRL;
                    {F7_ALT,  3'b101}: d.alu = ALU_SRA;
                    {F7_M,    3'b100}: begin
                        d.alu   = ALU_DIV;
                        d.legal = (ENABLE_M != 0);
                    end
                    {F7_M,    3'b110}: begin
                        d.alu   = ALU_REM;
                        d.legal = (ENABLE_M != 0);
                    end
                    default: d.legal = 1'b0;
                endcase
            end
            OP_IMM:  d = '{legal: (f3 == 3'b000), alu: ALU_ADD, src: 1'b1, imm: IMM_I, wb: WB_ALU};
            OP_LW:   d = '{legal: (f3 == 3'b010), alu: ALU_ADD, src: 1'b1, imm: IMM_I, wb: WB_MEM};
            OP_SW:   d = '{legal: (f3 == 3'b010), alu: ALU_ADD, src: 1'b1, imm: IMM_S, wb: WB_ALU};
            OP_BEQ:  d = '{legal: (f3 == 3'b000), alu: ALU_SUB, src: 1'b0, imm: IMM_B, wb: WB_ALU};
            OP_JAL:  d = '{legal: 1'b1,           alu: ALU_ADD, src: 1'b0, imm: IMM_J, wb: WB_PC4};
            OP_JALR: d = '{legal: (f3 == 3'b000), alu: ALU_ADD, src: 1'b1, imm: IMM_I, wb: WB_PC4};
            OP_LUI:  d = '{legal: 1'b1,           alu: ALU_ADD, src: 1'b0, imm: IMM_U, wb: WB_IMM};
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    logic [2:0]       cur_state;
    logic [2:0]       next_state;
    logic [31:0]      ir_q;
    logic [3:0]       alu_control_q;
    logic             alu_src_q;
    logic [2:0]       imm_control_q;
    logic [1:0]       wb_sel_q;
    logic [1:0]       pc_src_q;
    logic             trap_q;
    logic [1:0]       trap_cause_q;
    logic [CNT_W-1:0] wait_cnt;

    dec_t       dec;
    logic [6:0] op;
    logic       is_md;
    logic       is_sw;
    logic       limit_hit;
    logic       waiting;
    logic       unused_ir_bits;

    logic       imem_req_c;
    logic       dmem_req_c;
    logic       alu_start_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;
    logic       mem_write_c;
    logic [1:0] pc_src_c;

    assign op        = ir_q[6:0];
    assign is_md     = (op == OP_R) && (ir_q[31:25] == F7_M);
    assign is_sw     = (op == OP_SW);
    // Trip on the wait cycle that would bring the count up to WAIT_LIMIT.
    assign limit_hit = (WAIT_LIMIT != 0) && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
    // Register-select fields are consumed by the datapath, not by control.
    assign unused_ir_bits = ^ir_q[24:15];

    // Decode of the latched instruction; only consumed while in DECODE.
    always_comb begin
        dec = decode(ir_q);
    end

    // Next state and strobes; a timeout cycle deliberately issues no strobes.
    always_comb begin
        next_state  = cur_state;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        alu_start_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        pc_src_c    = PC_PLUS4;
        waiting     = 1'b0;
        case (cur_state)
            FETCH: begin
                waiting = !bus.imem_ready;
                if (bus.imem_ready) begin
                    imem_req_c = 1'b1;
                    ir_write_c = 1'b1;
                    next_state = DECODE;
                end else if (limit_hit) begin
                    next_state = TRAP;
                end else begin
                    imem_req_c = 1'b1;
                end
            end
            DECODE: next_state = dec.legal ? EXEC : TRAP;
            EXEC: begin
                if (is_md) begin
                    alu_start_c = 1'b1;
                    next_state  = ALU_WAIT;
                end else if (op == OP_BEQ) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = bus.alu_zero ? PC_BRANCH : PC_PLUS4;
                    next_state = FETCH;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    next_state = MEM;
                end else begin
                    next_state = WB;
                end
            end
            ALU_WAIT: begin
                waiting = !bus.alu_done;
                if (bus.alu_done) begin
                    next_state = WB;
                end else if (limit_hit) begin
                    next_state = TRAP;
                end
            end
            MEM: begin
                waiting = !bus.dmem_ready;
                if (bus.dmem_ready) begin
                    dmem_req_c  = 1'b1;
                    mem_write_c = is_sw;
                    if (is_sw) begin
                        pc_write_c = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WB;
                    end
                end else if (limit_hit) begin
                    next_state = TRAP;
                end else begin
                    dmem_req_c  = 1'b1;
                    mem_write_c = is_sw;
                end
            end
            WB: begin
                reg_write_c = (ir_q[11:7] != 5'd0);
                pc_write_c  = 1'b1;
                if (op == OP_JAL) begin
                    pc_src_c = PC_JAL;
                end else if (op == OP_JALR) begin
                    pc_src_c = PC_JALR;
                end
                next_state = FETCH;
            end
            TRAP:    next_state = TRAP;
            default: next_state = TRAP;
        endcase
    end

    // State, instruction, decoded controls, trap status and watchdog count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state     <= FETCH;
            ir_q          <= '0;
            alu_control_q <= '0;
            alu_src_q     <= 1'b0;
            imm_control_q <= '0;
            wb_sel_q      <= '0;
            pc_src_q      <= '0;
            trap_q        <= 1'b0;
            trap_cause_q  <= '0;
            wait_cnt      <= '0;
        end else begin
            cur_state <= next_state;
            if (ir_write_c) begin
                ir_q <= bus.inst;
            end
            if ((cur_state == DECODE) && dec.legal) begin
                alu_control_q <= dec.alu;
                alu_src_q     <= dec.src;
                imm_control_q <= dec.imm;
                wb_sel_q      <= dec.wb;
            end
            if (pc_write_c) begin
                pc_src_q <= pc_src_c;
            end
            if ((next_state == TRAP) && (cur_state != TRAP)) begin
                trap_q       <= 1'b1;
                trap_cause_q <= (cur_state == DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
            end
            if (next_state != cur_state) begin
                wait_cnt <= '0;
            end else if (waiting && (WAIT_LIMIT != 0)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Strobes are silenced while reset is held so an aborted instruction
    // cannot write anything on the reset cycle.
    assign bus.imem_req    = rst_n & imem_req_c;
    assign bus.dmem_req    = rst_n & dmem_req_c;
    assign bus.alu_start   = rst_n & alu_start_c;
    assign bus.ir_write    = rst_n & ir_write_c;
    assign bus.pc_write    = rst_n & pc_write_c;
    assign bus.reg_write   = rst_n & reg_write_c;
    assign bus.mem_write   = rst_n & mem_write_c;
    // Live select while the PC is written, otherwise the last one used.
    assign bus.pc_src      = bus.pc_write ? pc_src_c : pc_src_q;
    assign bus.wb_sel      = wb_sel_q;
    assign bus.alu_control = alu_control_q;
    assign bus.imm_control = imm_control_q;
    assign bus.alu_src     = alu_src_q;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = trap_cause_q;
    assign bus.state       = cur_state;
endmodule
